// File: rtl/key_schedule_ctrl_pkg.sv
// Shared constants and state encoding for the AES-128 key schedule controller.
package key_schedule_ctrl_pkg;

    localparam int        AES_NR    = 10;      // number of round keys after rk0
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;  // x^8 reduction term for xtime
    localparam int        KEY_W     = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

endpackage

// File: rtl/inverse_key_expansion.sv
// Combinational AES-128 key expansion round: next round key from the previous
// one and the round constant word RC = {rcon, 24'h0}.
import key_schedule_ctrl_pkg::*;

module inverse_key_expansion (
    input  logic [31:0]      RC,
    input  logic [KEY_W-1:0] in,
    output logic [KEY_W-1:0] out
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, which maps 0 to 0) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(gf_mul(x15, x15), gf_mul(x15, x15));
        x240 = gf_mul(gf_mul(x240, x240), gf_mul(x240, x240));
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = in;
    assign temp = sub_word({w3[23:0], w3[31:24]}) ^ RC;
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;
    assign out  = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: expands a cipher key into 11 round-key
// slots, one round per clock, and serves them through a registered read port.
import key_schedule_ctrl_pkg::*;

module key_schedule_ctrl #(
    parameter int REVERSE = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [KEY_W-1:0]              key,
    input  logic [3:0]                    rk_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          rk_valid,
    output logic [KEY_W-1:0]              rk_out,
    output logic [KEY_W*(AES_NR+1)-1:0]   keys_flat
);

    localparam logic [3:0] LAST_RND = 4'(AES_NR);

    state_t           state;
    logic [3:0]       rnd;
    logic [7:0]       rcon;
    logic [KEY_W-1:0] slot [0:AES_NR];
    logic [KEY_W-1:0] prev_key;
    logic [KEY_W-1:0] next_key;
    logic [3:0]       slot_sel;
    logic             idx_ok;

    // Select the previous round key feeding the shared round function
    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        prev_key = '0;
        if (rnd >= 4'd1 && rnd <= LAST_RND)
            prev_key = slot[rnd - 4'd1];
    end

    inverse_key_expansion u_round (
        .RC  ({rcon, 24'h0}),
        .in  (prev_key),
        .out (next_key)
    );

    // Map the read index onto a slot, honouring decryption order
    always_comb begin
        idx_ok   = (rk_idx <= LAST_RND);
        slot_sel = (REVERSE != 0) ? (LAST_RND - rk_idx) : rk_idx;
    end

    // Control FSM: accept start, run ten expansion rounds, then hold READY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rnd   <= 4'd0;
            rcon  <= RCON_INIT;
            // NOTE: the key slots are reset too, so no stale key material
            // survives an aborted or reset expansion.
            for (int i = 0; i <= AES_NR; i++) slot[i] <= '0;
        end else begin
            // NOTE: all state uses <= so every register samples pre-edge values.
            done <= 1'b0;
            case (state)
                IDLE, READY: begin
                    if (start) begin
                        slot[0] <= key;
                        rnd     <= 4'd1;
                        rcon    <= RCON_INIT;
                        busy    <= 1'b1;
                        state   <= EXPAND;
                    end
                end
                EXPAND: begin
                    slot[rnd] <= next_key;
                    rnd       <= rnd + 4'd1;
                    rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? RCON_POLY : 8'h00);
                    if (rnd == LAST_RND) begin
                        state <= READY;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered read port; a restart request invalidates it on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_out   <= '0;
            rk_valid <= 1'b0;
        end else if (state == READY && !start && idx_ok) begin
            rk_out   <= slot[slot_sel];
            rk_valid <= 1'b1;
        end else begin
            rk_out   <= '0;
            rk_valid <= 1'b0;
        end
    end

    // Flattened view of all round keys, rk0 in the top word, only when READY
    always_comb begin
        keys_flat = '0;
        if (state == READY)
            for (int i = 0; i <= AES_NR; i++)
                keys_flat[KEY_W*(AES_NR-i) +: KEY_W] = slot[i];
    end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 SHALL have parameter: REVERSE, default 0, 0 = rk_idx k returns round key k; 1 = rk_idx k returns round key 10-k (decryption order).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to expand key; sampled on clk.
REQ-005 SHALL have port: key  input  128  cipher key; sampled only on the edge where start is accepted.
REQ-006 SHALL have port: rk_idx  input  4  round-key read index, 0..10.
REQ-007 SHALL have port: busy  output  1  high while expansion is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse on expansion completion.
REQ-009 SHALL have port: rk_valid  output  1  registered; high when rk_out holds a valid key.
REQ-010 SHALL have port: rk_out  output  128  registered round key selected by rk_idx.
REQ-011 SHALL have port: keys_flat  output  1408  {rk0..rk10}, rk0 in bits [1407:1280]; zero unless state is READY.

Function
REQ-012 SHALL implement FSM states IDLE, EXPAND and READY.
REQ-013 SHALL make the following transitions: IDLE/READY + start -> EXPAND; EXPAND + final round written -> READY; otherwise hold.
REQ-014 SHALL, on the accepting edge (E0), write key to slot 0, set the round counter to 1 and set rcon to 8'h01.
REQ-015 SHALL, on each EXPAND edge, compute slot[rnd] = round_fn(slot[rnd-1], {rcon,24'h0}), increment rnd and set rcon = xtime(rcon) (shift left 1, XOR 8'h1B on carry-out).
REQ-016 SHALL write exactly ten rounds, at edges E1..E10; rcon takes the sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-017 SHALL hold busy = 1 after E0 through E10 and 0 otherwise.
REQ-018 SHALL hold done = 1 for exactly the cycle after E10 and enter READY at E10.
REQ-019 SHALL ignore start while in EXPAND; no restart and key is not resampled.
REQ-020 SHALL, on start in READY, clear rk_valid at the next edge and restart expansion from E0 with the new key.
REQ-021 SHALL have read latency of one cycle: rk_out/rk_valid at edge N reflect rk_idx sampled at edge N.
REQ-022 SHALL, when the state is not READY or rk_idx > 10, drive rk_out = 0 and rk_valid = 0.
REQ-023 SHALL, with REVERSE = 1, map rk_idx 0 to slot 10 and rk_idx 10 to slot 0; out-of-range handling is per REQ-022.
REQ-024 SHALL use a single round_fn instance; the slot storage is 11 x 128-bit registers.

Reset
REQ-025 SHALL, on rst assertion, immediately and without a clock edge, set the state to IDLE, busy = 0, done = 0, rk_valid = 0, rk_out = 0, all slots = 0, rnd = 0 and rcon = 8'h01.
REQ-026 SHALL abort any in-progress expansion on rst during EXPAND; no done pulse results, and the first start after rst release restarts from E0.
REQ-027 SHALL ignore start while rst is high.

Structure
REQ-028 SHALL place the shared package constants there: AES_NR = 10, RCON_INIT = 8'h01, RCON_POLY = 8'h1B, KEY_W = 128, and the state enum {IDLE, EXPAND, READY}.
REQ-029 SHALL instantiate the existing combinational inverse_key_expansion round function (ports RC, in, out) as the sole sub-module.
REQ-030 SHALL keep xtime for rcon inline; no further sub-modules.

Verification
REQ-031 SHALL verify key 000102030405060708090a0b0c0d0e0f, start for 1 cycle -> done 11 cycles after start edge; rk_idx 1 = d6aa74fdd2af72fadaa678f1d6ab76fe; rk_idx 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-032 SHALL verify key 2b7e151628aed2a6abf7158809cf4f3c with REVERSE = 1 -> rk_idx 0 = d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx 10 = the key itself.
REQ-033 SHALL verify start pulsed again at E5 with a different key -> ignored; results are identical to REQ-031 and there is a single done pulse.
REQ-034 SHALL verify rst asserted at E4 -> busy, rk_valid and keys_flat are 0 immediately, no done pulse; a new start then yields the REQ-031 values.
REQ-035 SHALL verify rk_idx = 11 and 15 in READY -> rk_out = 0 and rk_valid = 0; rk_idx = 0 next cycle -> rk_valid = 1.
REQ-036 SHALL verify restart from READY -> rk_valid drops the cycle after start, keys_flat = 0 during EXPAND and holds new keys after done.
